// File: rtl/backend_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | backend_multi: serial-configured gain/reset registers for NCH front-end  |
// | channels plus a two-VCO edge-count frequency comparator.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module backend_multi #(
    parameter int NCH           = 4,
    parameter int GAINW         = 3,
    parameter int WIN_CYCLES    = 1024,
    parameter int CNTW          = 12,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                 i_clk,
    input  logic                 i_resetAll,
    input  logic                 i_sclk,
    input  logic                 i_sdin,
    input  logic                 i_sen,
    input  logic [NCH-1:0]       i_clk_vco,
    output logic [NCH*GAINW-1:0] o_gain,
    output logic [NCH-1:0]       o_resetb,
    output logic [NCH-1:0]       o_resetbvco,
    output logic                 o_busy,
    output logic                 o_ready,
    output logic                 o_fast,
    output logic                 o_equal,
    output logic                 o_err
);
    localparam int IDXW = $clog2(NCH);
    localparam int TMAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
    localparam int TMRW = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TMRW-1:0] SETTLE_LOAD = TMRW'(SETTLE_CYCLES - 1);
    localparam logic [TMRW-1:0] WIN_LOAD    = TMRW'(WIN_CYCLES - 1);
    localparam logic [CNTW-1:0] CNT_MAX     = '1;
    localparam logic [4:0]      BITS_MAX    = 5'd31;
    localparam logic [4:0]      FRAME_BITS  = 5'd16;
    localparam logic [3:0]      CMD_WRGAIN  = 4'h1;
    localparam logic [3:0]      CMD_WRRST   = 4'h2;
    localparam logic [3:0]      CMD_MEAS    = 4'h3;

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_COUNT, ST_DONE} state_t;

    // [0] first sync flop, [1] second sync flop, [2] edge-detect history
    logic [2:0] sclk_s_q, sen_s_q;
    logic [1:0] sdin_s_q;
    logic [NCH-1:0] vco_s1_q, vco_s2_q, vco_s3_q;

    logic [15:0] shift_q, shift_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic        fr_done_q, fr_len_ok_q;
    logic [15:0] fr_word_q, fr_word_d;

    logic            dec_gain_q, dec_gain_d, dec_rst_q, dec_rst_d;
    logic            dec_meas_q, dec_meas_d, dec_err_q, dec_err_d;
    logic [IDXW-1:0] dec_cha_q, dec_chb_q;
    logic [7:0]      dec_data_q;

    logic [NCH-1:0][GAINW-1:0] gain_q, gain_d;
    logic [NCH-1:0]  resetb_q, resetb_d, vcorst_q, vcorst_d;
    logic            busy_q, busy_d, ready_q, ready_d, fast_q, fast_d;
    logic            equal_q, equal_d, err_q, err_d;
    state_t          state_q, state_d;
    logic [TMRW-1:0] timer_q, timer_d;
    logic [IDXW-1:0] a_q, a_d, b_q, b_d;
    logic [CNTW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

    logic            sclk_rise, sen_rise, sen_fall;
    logic [NCH-1:0]  vco_rise;
    logic [3:0]      cmd;
    logic            cha_bad, chb_bad, known_cmd, meas_go;
    logic            unused_bits;

    assign sclk_rise = sclk_s_q[1] & ~sclk_s_q[2];
    assign sen_rise  = sen_s_q[1] & ~sen_s_q[2];
    assign sen_fall  = ~sen_s_q[1] & sen_s_q[2];
    assign vco_rise  = vco_s2_q & ~vco_s3_q;

    assign cmd       = fr_word_q[15:12];
    assign cha_bad   = {28'd0, fr_word_q[11:8]} >= NCH;
    assign chb_bad   = {28'd0, fr_word_q[3:0]} >= NCH;
    assign known_cmd = (cmd == CMD_WRGAIN) || (cmd == CMD_WRRST) || (cmd == CMD_MEAS);
    assign meas_go   = dec_meas_q & ~busy_q;
    assign unused_bits = ^dec_data_q;

    // Shift/capture, decode and register-write pipeline
    always_comb begin
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        if (sen_rise) begin
            bitcnt_d = '0;
        end else if (sen_s_q[1] && sclk_rise) begin
            shift_d = {shift_q[14:0], sdin_s_q[1]};
            if (bitcnt_q != BITS_MAX) bitcnt_d = bitcnt_q + 5'd1;
        end
        fr_word_d = sen_fall ? shift_q : fr_word_q;

        dec_gain_d = fr_done_q & fr_len_ok_q & ~cha_bad & (cmd == CMD_WRGAIN);
        dec_rst_d  = fr_done_q & fr_len_ok_q & ~cha_bad & (cmd == CMD_WRRST);
        dec_meas_d = fr_done_q & fr_len_ok_q & ~cha_bad & ~chb_bad & (cmd == CMD_MEAS);
        dec_err_d  = fr_done_q & (~fr_len_ok_q | (known_cmd & cha_bad) |
                                  ((cmd == CMD_MEAS) & chb_bad));

        gain_d   = gain_q;
        resetb_d = resetb_q;
        if (dec_gain_q) gain_d[dec_cha_q]   = dec_data_q[GAINW-1:0];
        if (dec_rst_q)  resetb_d[dec_cha_q] = dec_data_q[0];
        err_d = dec_err_q | (dec_meas_q & busy_q);
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_a_d  = cnt_a_q;
        cnt_b_d  = cnt_b_q;
        ready_d  = ready_q;
        fast_d   = fast_q;
        equal_d  = equal_q;
        vcorst_d = vcorst_q;
        // Busy lags the return to IDLE by one cycle so it falls after ready
        busy_d   = meas_go | (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (meas_go) begin
                    state_d = ST_SETTLE;
                    timer_d = SETTLE_LOAD;
                    a_d     = dec_cha_q;
                    b_d     = dec_chb_q;
                    cnt_a_d = '0;
                    cnt_b_d = '0;
                    ready_d = 1'b0;
                    fast_d  = 1'b0;
                    equal_d = 1'b0;
                    vcorst_d[dec_cha_q] = 1'b1;
                    vcorst_d[dec_chb_q] = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (timer_q == '0) begin
                    state_d = ST_COUNT;
                    timer_d = WIN_LOAD;
                end else begin
                    timer_d = timer_q - TMRW'(1);
                end
            end
            ST_COUNT: begin
                if (vco_rise[a_q] && cnt_a_q != CNT_MAX) cnt_a_d = cnt_a_q + CNTW'(1);
                if (vco_rise[b_q] && cnt_b_q != CNT_MAX) cnt_b_d = cnt_b_q + CNTW'(1);
                if (timer_q == '0) state_d = ST_DONE;
                else               timer_d = timer_q - TMRW'(1);
            end
            default: begin
                fast_d  = cnt_a_q > cnt_b_q;
                equal_d = cnt_a_q == cnt_b_q;
                ready_d = 1'b1;
                vcorst_d[a_q] = 1'b0;
                vcorst_d[b_q] = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_resetAll) begin
        if (i_resetAll) begin
            sclk_s_q    <= '0;
            sen_s_q     <= '0;
            sdin_s_q    <= '0;
            vco_s1_q    <= '0;
            vco_s2_q    <= '0;
            vco_s3_q    <= '0;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            fr_done_q   <= 1'b0;
            fr_len_ok_q <= 1'b0;
            fr_word_q   <= '0;
            dec_gain_q  <= 1'b0;
            dec_rst_q   <= 1'b0;
            dec_meas_q  <= 1'b0;
            dec_err_q   <= 1'b0;
            dec_cha_q   <= '0;
            dec_chb_q   <= '0;
            dec_data_q  <= '0;
            gain_q      <= '0;
            resetb_q    <= '0;
            vcorst_q    <= '0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            fast_q      <= 1'b0;
            equal_q     <= 1'b0;
            err_q       <= 1'b0;
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
        end else begin
            sclk_s_q    <= {sclk_s_q[1:0], i_sclk};
            sen_s_q     <= {sen_s_q[1:0], i_sen};
            sdin_s_q    <= {sdin_s_q[0], i_sdin};
            vco_s1_q    <= i_clk_vco;
            vco_s2_q    <= vco_s1_q;
            vco_s3_q    <= vco_s2_q;
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            fr_done_q   <= sen_fall;
            fr_len_ok_q <= (bitcnt_q == FRAME_BITS);
            fr_word_q   <= fr_word_d;
            dec_gain_q  <= dec_gain_d;
            dec_rst_q   <= dec_rst_d;
            dec_meas_q  <= dec_meas_d;
            dec_err_q   <= dec_err_d;
            dec_cha_q   <= fr_word_q[8 +: IDXW];
            dec_chb_q   <= fr_word_q[0 +: IDXW];
            dec_data_q  <= fr_word_q[7:0];
            gain_q      <= gain_d;
            resetb_q    <= resetb_d;
            vcorst_q    <= vcorst_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            fast_q      <= fast_d;
            equal_q     <= equal_d;
            err_q       <= err_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
        end
    end

    assign o_gain      = gain_q;
    assign o_resetb    = resetb_q;
    assign o_resetbvco = vcorst_q;
    assign o_busy      = busy_q;
    assign o_ready     = ready_q;
    assign o_fast      = fast_q;
    assign o_equal     = equal_q;
    assign o_err       = err_q;
endmodule
`default_nettype wire
